mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the CPU's single memory bus port between the instruction-fetch requester (IF) and the load/store requester (LS). It sits between the multicycle control sequencer's fetch/memory phases and the external Avalon-style memory interface. It serialises accesses, holds bus signals stable across wait states and returns read data with a one-cycle completion pulse. Round-robin arbitration applies when both requesters are pending.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be a multiple of 8; BE_W = DATA_W/8

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held high until if_done
- if_addr  in  ADDR_W  fetch address; stable while if_req high
- if_done  out  1  one-cycle pulse: fetch complete
- if_rdata  out  DATA_W  fetched word, valid from if_done onward
- ls_req  in  1  load/store request; held high until ls_done
- ls_write  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  data address
- ls_wdata  in  DATA_W  store data
- ls_byteen  in  BE_W  store/load byte enables
- ls_done  out  1  one-cycle pulse: load/store complete
- ls_rdata  out  DATA_W  load data, valid from ls_done onward
- address  out  ADDR_W  memory address
- read  out  1  memory read strobe
- write  out  1  memory write strobe
- writedata  out  DATA_W  memory write data
- byteenable  out  BE_W  memory byte enables
- readdata  in  DATA_W  memory read data, valid when waitrequest low during read
- waitrequest  in  1  memory stall

## Operation
- FSM states: IDLE, BUS, DONE. All outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one of if_req/ls_req: grant it.
  - Both requesting: grant the port not recorded in last_grant; update last_grant.
  - On grant: latch owner plus address/read/write/writedata/byteenable from the granted port; go to BUS.
- Signal mapping:
  - IF grant: read=1, write=0, byteenable=all ones, writedata=0.
  - LS grant: read=~ls_write, write=ls_write, byteenable=ls_byteen, writedata=ls_wdata.
- BUS: bus outputs are held constant.
  - waitrequest=1 at an edge: stay in BUS.
  - waitrequest=0 at an edge: transfer accepted. Clear read/write; go to DONE. If the access was a read, capture readdata into the owner's rdata register.
- DONE: assert the owner's done for this cycle only, then go to IDLE.
- Requester rules:
  - Drop or change req no earlier than the done cycle.
  - req/address changes while not in IDLE are ignored, because the bus values are latched.
- if_rdata/ls_rdata:
  - Each holds its last captured value until that port's next read completes.
  - Stores never modify ls_rdata.
- A byteenable of zero on a store is still issued as a bus transaction.
- Addresses are passed through unmodified, with no alignment checking.
- last_grant resets to LS, so the first simultaneous request goes to IF.

## Timing
- Reset values: read=0, write=0, address=0, writedata=0, byteenable=0, if_done=0, ls_done=0, if_rdata=0, ls_rdata=0, state=IDLE, last_grant=LS.
- reset has priority over all other inputs. Asserted mid-transaction, it deasserts read/write on the next edge and abandons the transaction with no done pulse. Memory-side recovery is the memory's concern.
- Zero-wait latency:
  - req is sampled at edge E0.
  - Bus strobes are high in cycle E0..E1.
  - The transfer is accepted at E1.
  - done is high in E1..E2.
  - IDLE in E2..E3; a new request is sampled at E3.
- Minimum cost is 3 cycles per access; each waitrequest cycle adds 1.
- read and write are never high together. Only one done is high in any cycle.
- A requester that keeps req high through DONE gets a fresh transaction arbitrated in IDLE. In the multicycle CPU, the sequencer drops req on done.
- waitrequest is ignored outside BUS.

## Test plan
- Single fetch:
  - Stimulus: after reset, if_req=1, if_addr=0xBFC00000, waitrequest=0, readdata=0x24020005.
  - Required: read=1 and address=0xBFC00000 for 1 cycle; if_done pulses 1 cycle later; if_rdata=0x24020005; ls_done stays 0.
- Store with wait states:
  - Stimulus: ls_req=1, ls_write=1, ls_addr=0x1000, ls_wdata=0xDEADBEEF, ls_byteen=4'b0011, waitrequest=1 for 3 cycles.
  - Required: write held high with stable address/writedata/byteenable for 4 cycles; ls_done pulses once; ls_rdata unchanged.
- Simultaneous requests:
  - Stimulus: if_req and ls_req both high from reset and re-raised after each done.
  - Required: grants alternate IF, LS, IF, LS; every transaction takes exactly 3 cycles with waitrequest=0.
- Load:
  - Stimulus: ls_req=1, ls_write=0, ls_addr=0x2004, ls_byteen=4'b1111, readdata=0x0000007F, waitrequest=1 for 1 cycle.
  - Required: ls_rdata=0x0000007F at ls_done; if_rdata unchanged.
- Reset mid-operation:
  - Stimulus: assert reset while in BUS with waitrequest=1.
  - Required: next cycle read=write=0, no done pulse, all outputs at reset values; a following fetch completes normally.
- Input change during BUS:
  - Stimulus: change ls_addr from 0x3000 to 0x4000 while in BUS.
  - Required: address stays 0x3000 until the transfer is accepted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single Avalon-style memory port: instruction fetch (IF)
// and load/store (LS) share the bus, with round-robin priority when both are pending.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int BE_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    // instruction-fetch requester
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    // load/store requester
    input  logic              ls_req,
    input  logic              ls_write,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [BE_W-1:0]   ls_byteen,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    // memory port
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    output logic [BE_W-1:0]   byteenable,
    input  logic [DATA_W-1:0] readdata,
    input  logic              waitrequest
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_DONE
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

    state_t state;
    owner_t owner;
    owner_t last_grant;

    logic   grant_valid;
    owner_t pick;

    // NOTE: every signal assigned in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_valid = if_req || ls_req;
        pick        = OWN_IF;
        if (if_req && ls_req) begin
            pick = (last_grant == OWN_IF) ? OWN_LS : OWN_IF;
        end else if (ls_req) begin
            pick = OWN_LS;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values and the block order does not matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            owner      <= OWN_IF;
            last_grant <= OWN_LS;
            address    <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            writedata  <= '0;
            byteenable <= '0;
            if_done    <= 1'b0;
            ls_done    <= 1'b0;
            if_rdata   <= '0;
            ls_rdata   <= '0;
        end else begin
            if_done <= 1'b0;
            ls_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner      <= pick;
                        last_grant <= pick;
                        state      <= ST_BUS;
                        if (pick == OWN_IF) begin
                            address    <= if_addr;
                            read       <= 1'b1;
                            write      <= 1'b0;
                            writedata  <= '0;
                            byteenable <= '1;
                        end else begin
                            address    <= ls_addr;
                            read       <= ~ls_write;
                            write      <= ls_write;
                            writedata  <= ls_wdata;
                            byteenable <= ls_byteen;
                        end
                    end
                end

                ST_BUS: begin
                    // Bus fields stay latched; only the strobes drop once accepted.
                    if (!waitrequest) begin
                        read  <= 1'b0;
                        write <= 1'b0;
                        state <= ST_DONE;
                        if (owner == OWN_IF) begin
                            if_done <= 1'b1;
                            if (read) if_rdata <= readdata;
                        end else begin
                            ls_done <= 1'b1;
                            if (read) ls_rdata <= readdata;
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Structural invariants of the port protocol.
    assert property (@(posedge clk) disable iff (reset) !(read && write));
    assert property (@(posedge clk) disable iff (reset) !(if_done && ls_done));
    assert property (@(posedge clk) disable iff (reset) (read || write) |-> (state == ST_BUS));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of requesters, round-robin and memory.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;
    logic              ls_req;
    logic              ls_write;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic [BE_W-1:0]   ls_byteen;
    logic              ls_done;
    logic [DATA_W-1:0] ls_rdata;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    int checks = 0;
    int errors = 0;

    // Expected read-data registers, tracked by the bench from completed reads.
    logic [DATA_W-1:0] exp_if_rdata;
    logic [DATA_W-1:0] exp_ls_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_done    (if_done),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_write   (ls_write),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_byteen  (ls_byteen),
        .ls_done    (ls_done),
        .ls_rdata   (ls_rdata),
        .address    (address),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .byteenable (byteenable),
        .readdata   (readdata),
        .waitrequest(waitrequest)
    );

    // Protocol invariants observed every cycle, away from the active edge.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            checks++;
            if ((read && write) || (if_done && ls_done)) begin
                errors++;
                $display("FAIL invariant: read=%b write=%b if_done=%b ls_done=%b, need no overlap",
                         read, write, if_done, ls_done);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset        = 1'b0;
        exp_if_rdata = '0;
        exp_ls_rdata = '0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        if_req      = 1'b0;
        if_addr     = '0;
        ls_req      = 1'b0;
        ls_write    = 1'b0;
        ls_addr     = '0;
        ls_wdata    = '0;
        ls_byteen   = '0;
        readdata    = '0;
        waitrequest = 1'b0;
        tick();
        tick();
        checks++;
        if ({read, write, if_done, ls_done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got %b, need 0000", {read, write, if_done, ls_done});
        end
        checks++;
        if ({address, writedata, byteenable} !== '0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h wdata=%h be=%h, need all zero", address, writedata, byteenable);
        end
        checks++;
        if ({if_rdata, ls_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_rdata: if_rdata=%h ls_rdata=%h, need zero", if_rdata, ls_rdata);
        end
        reset        = 1'b0;
        exp_if_rdata = '0;
        exp_ls_rdata = '0;
    endtask

    task automatic test_single_fetch();
        if_addr     = 32'hBFC0_0000;
        readdata    = 32'h2402_0005;
        waitrequest = 1'b0;
        if_req      = 1'b1;
        tick();
        checks++;
        if (!(read === 1'b1 && write === 1'b0 && address === 32'hBFC0_0000 &&
              byteenable === 4'hF && writedata === '0 && if_done === 1'b0)) begin
            errors++;
            $display("FAIL fetch_bus: rd=%b wr=%b addr=%h be=%h wd=%h done=%b, need 1 0 bfc00000 f 0 0",
                     read, write, address, byteenable, writedata, if_done);
        end
        tick();
        exp_if_rdata = 32'h2402_0005;
        checks++;
        if (!(read === 1'b0 && if_done === 1'b1 && ls_done === 1'b0)) begin
            errors++;
            $display("FAIL fetch_done: rd=%b if_done=%b ls_done=%b, need 0 1 0", read, if_done, ls_done);
        end
        checks++;
        if (if_rdata !== exp_if_rdata) begin
            errors++;
            $display("FAIL fetch_rdata: got %h, need %h", if_rdata, exp_if_rdata);
        end
        if_req   = 1'b0;
        readdata = 32'hFFFF_FFFF;
        tick();
        checks++;
        if (!(if_done === 1'b0 && read === 1'b0)) begin
            errors++;
            $display("FAIL fetch_pulse: if_done=%b read=%b one cycle after done, need 0 0", if_done, read);
        end
        tick();
        checks++;
        if (!(read === 1'b0 && if_rdata === exp_if_rdata && ls_done === 1'b0)) begin
            errors++;
            $display("FAIL fetch_idle: read=%b if_rdata=%h ls_done=%b, need 0 %h 0",
                     read, if_rdata, ls_done, exp_if_rdata);
        end
    endtask

    task automatic test_store_wait();
        ls_write    = 1'b1;
        ls_addr     = 32'h0000_1000;
        ls_wdata    = 32'hDEAD_BEEF;
        ls_byteen   = 4'b0011;
        waitrequest = 1'b1;
        readdata    = 32'h5555_AAAA;
        ls_req      = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (!(write === 1'b1 && read === 1'b0 && address === 32'h0000_1000 &&
                  writedata === 32'hDEAD_BEEF && byteenable === 4'b0011 && ls_done === 1'b0)) begin
                errors++;
                $display("FAIL store_hold[%0d]: wr=%b rd=%b addr=%h wd=%h be=%b done=%b, need 1 0 1000 deadbeef 0011 0",
                         c, write, read, address, writedata, byteenable, ls_done);
            end
            if (c == 3) waitrequest = 1'b0;
        end
        tick();
        checks++;
        if (!(write === 1'b0 && ls_done === 1'b1 && if_done === 1'b0 && ls_rdata === exp_ls_rdata)) begin
            errors++;
            $display("FAIL store_done: wr=%b ls_done=%b if_done=%b ls_rdata=%h, need 0 1 0 %h",
                     write, ls_done, if_done, ls_rdata, exp_ls_rdata);
        end
        ls_req = 1'b0;
        tick();
        checks++;
        if (!(ls_done === 1'b0 && write === 1'b0 && ls_rdata === exp_ls_rdata)) begin
            errors++;
            $display("FAIL store_pulse: ls_done=%b write=%b ls_rdata=%h, need 0 0 %h",
                     ls_done, write, ls_rdata, exp_ls_rdata);
        end
    endtask

    task automatic test_load();
        ls_write    = 1'b0;
        ls_addr     = 32'h0000_2004;
        ls_byteen   = 4'b1111;
        readdata    = 32'h0000_007F;
        waitrequest = 1'b1;
        ls_req      = 1'b1;
        tick();
        checks++;
        if (!(read === 1'b1 && write === 1'b0 && address === 32'h0000_2004 && byteenable === 4'hF)) begin
            errors++;
            $display("FAIL load_bus: rd=%b wr=%b addr=%h be=%h, need 1 0 2004 f", read, write, address, byteenable);
        end
        tick();
        checks++;
        if (!(read === 1'b1 && ls_done === 1'b0 && ls_rdata === exp_ls_rdata)) begin
            errors++;
            $display("FAIL load_wait: rd=%b ls_done=%b ls_rdata=%h, need 1 0 %h", read, ls_done, ls_rdata, exp_ls_rdata);
        end
        waitrequest = 1'b0;
        tick();
        exp_ls_rdata = 32'h0000_007F;
        checks++;
        if (!(ls_done === 1'b1 && ls_rdata === exp_ls_rdata && if_rdata === exp_if_rdata)) begin
            errors++;
            $display("FAIL load_done: ls_done=%b ls_rdata=%h if_rdata=%h, need 1 %h %h",
                     ls_done, ls_rdata, if_rdata, exp_ls_rdata, exp_if_rdata);
        end
        ls_req = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        logic [ADDR_W-1:0] a_if;
        logic [ADDR_W-1:0] a_ls;
        int                n;
        int                p;
        logic              own_ls;
        logic [DATA_W-1:0] rd;
        apply_reset();
        a_if        = 32'h0040_0000;
        a_ls        = 32'h1001_0000;
        if_addr     = a_if;
        ls_addr     = a_ls;
        ls_write    = 1'b0;
        ls_byteen   = 4'hF;
        waitrequest = 1'b0;
        if_req      = 1'b1;
        ls_req      = 1'b1;
        rd          = '0;
        // Transaction n occupies samples 3n+1 (bus), 3n+2 (done), 3n+3 (idle).
        for (int k = 1; k <= 12; k++) begin
            tick();
            n      = (k - 1) / 3;
            p      = (k - 1) % 3;
            own_ls = (n % 2) == 1;
            checks++;
            if (read !== (p == 0) || if_done !== (p == 1 && !own_ls) || ls_done !== (p == 1 && own_ls)) begin
                errors++;
                $display("FAIL rr_cycle[%0d]: rd=%b if_done=%b ls_done=%b, need %b %b %b",
                         k, read, if_done, ls_done, p == 0, p == 1 && !own_ls, p == 1 && own_ls);
            end
            if (p == 0) begin
                checks++;
                if (address !== (own_ls ? a_ls : a_if)) begin
                    errors++;
                    $display("FAIL rr_grant[%0d]: addr=%h, need %h", n, address, own_ls ? a_ls : a_if);
                end
                rd       = $urandom;
                readdata = rd;
            end
            if (p == 1) begin
                if (own_ls) exp_ls_rdata = rd;
                else        exp_if_rdata = rd;
                checks++;
                if (if_rdata !== exp_if_rdata || ls_rdata !== exp_ls_rdata) begin
                    errors++;
                    $display("FAIL rr_rdata[%0d]: if=%h ls=%h, need %h %h",
                             n, if_rdata, ls_rdata, exp_if_rdata, exp_ls_rdata);
                end
            end
            if (k == 11) begin
                if_req = 1'b0;
                ls_req = 1'b0;
            end
        end
        tick();
        checks++;
        if (read !== 1'b0) begin
            errors++;
            $display("FAIL rr_stop: read=%b after requests dropped, need 0", read);
        end
    endtask

    task automatic test_reset_mid();
        ls_write    = 1'b0;
        ls_addr     = 32'h0000_5000;
        ls_byteen   = 4'hF;
        waitrequest = 1'b1;
        ls_req      = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({read, write, if_done, ls_done} !== 4'b0000 ||
            {address, writedata, byteenable, if_rdata, ls_rdata} !== '0) begin
            errors++;
            $display("FAIL midreset: rd=%b wr=%b ifd=%b lsd=%b addr=%h wd=%h be=%h ifr=%h lsr=%h, need all zero",
                     read, write, if_done, ls_done, address, writedata, byteenable, if_rdata, ls_rdata);
        end
        reset        = 1'b0;
        ls_req       = 1'b0;
        exp_if_rdata = '0;
        exp_ls_rdata = '0;
        tick();
        checks++;
        if ({read, write, ls_done, if_done} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_quiet: rd=%b wr=%b ls_done=%b if_done=%b, need 0000",
                     read, write, ls_done, if_done);
        end
        if_addr     = 32'h0000_0100;
        readdata    = 32'h1234_5678;
        waitrequest = 1'b0;
        if_req      = 1'b1;
        tick();
        checks++;
        if (!(read === 1'b1 && address === 32'h0000_0100)) begin
            errors++;
            $display("FAIL midreset_fetch_bus: rd=%b addr=%h, need 1 00000100", read, address);
        end
        tick();
        exp_if_rdata = 32'h1234_5678;
        checks++;
        if (!(if_done === 1'b1 && if_rdata === exp_if_rdata)) begin
            errors++;
            $display("FAIL midreset_fetch_done: if_done=%b if_rdata=%h, need 1 %h", if_done, if_rdata, exp_if_rdata);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_input_change();
        ls_write    = 1'b1;
        ls_addr     = 32'h0000_3000;
        ls_wdata    = 32'h0BAD_F00D;
        ls_byteen   = 4'b1100;
        waitrequest = 1'b1;
        ls_req      = 1'b1;
        tick();
        ls_addr  = 32'h0000_4000;
        ls_wdata = 32'h1111_2222;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (!(address === 32'h0000_3000 && writedata === 32'h0BAD_F00D && write === 1'b1)) begin
                errors++;
                $display("FAIL change_hold[%0d]: addr=%h wd=%h wr=%b, need 00003000 0badf00d 1",
                         c, address, writedata, write);
            end
        end
        waitrequest = 1'b0;
        tick();
        checks++;
        if (!(ls_done === 1'b1 && write === 1'b0 && address === 32'h0000_3000)) begin
            errors++;
            $display("FAIL change_done: ls_done=%b wr=%b addr=%h, need 1 0 00003000", ls_done, write, address);
        end
        ls_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic              if_pend;
        logic              ls_pend;
        logic [ADDR_W-1:0] m_if_a;
        logic              m_ls_w;
        logic [ADDR_W-1:0] m_ls_a;
        logic [DATA_W-1:0] m_ls_d;
        logic [BE_W-1:0]   m_ls_b;
        logic              last_ls;
        logic              g_ls;
        logic [69:0]       exp_bus;
        int                waits;
        logic [DATA_W-1:0] rd;
        apply_reset();
        if_pend = 1'b0;
        ls_pend = 1'b0;
        last_ls = 1'b1;
        for (int t = 0; t < 60; t++) begin
            if (!if_pend && $urandom_range(1, 0) == 1) begin
                if_pend = 1'b1;
                m_if_a  = $urandom;
                if_addr = m_if_a;
                if_req  = 1'b1;
            end
            if (!ls_pend && ($urandom_range(1, 0) == 1 || !if_pend)) begin
                ls_pend   = 1'b1;
                m_ls_w    = 1'($urandom_range(1, 0));
                m_ls_a    = $urandom;
                m_ls_d    = $urandom;
                m_ls_b    = 4'($urandom_range(15, 0));
                ls_write  = m_ls_w;
                ls_addr   = m_ls_a;
                ls_wdata  = m_ls_d;
                ls_byteen = m_ls_b;
                ls_req    = 1'b1;
            end
            g_ls    = (if_pend && ls_pend) ? !last_ls : ls_pend;
            last_ls = g_ls;
            exp_bus = g_ls ? {m_ls_a, !m_ls_w, m_ls_w, m_ls_d, m_ls_b}
                           : {m_if_a, 1'b1, 1'b0, 32'h0, 4'hF};
            waits       = $urandom_range(3, 0);
            waitrequest = 1'($urandom_range(1, 0));
            tick();
            for (int i = 0; i <= waits; i++) begin
                checks++;
                if ({address, read, write, writedata, byteenable} !== exp_bus || {if_done, ls_done} !== 2'b00) begin
                    errors++;
                    $display("FAIL rand_bus[%0d.%0d]: bus=%h done=%b%b, need %h 00",
                             t, i, {address, read, write, writedata, byteenable}, if_done, ls_done, exp_bus);
                end
                waitrequest = (i < waits);
                if (i == waits) begin
                    rd       = $urandom;
                    readdata = rd;
                end else begin
                    readdata = $urandom;
                    tick();
                end
            end
            tick();
            if (g_ls && !m_ls_w) exp_ls_rdata = rd;
            if (!g_ls)           exp_if_rdata = rd;
            checks++;
            if (read !== 1'b0 || write !== 1'b0 || if_done !== !g_ls || ls_done !== g_ls) begin
                errors++;
                $display("FAIL rand_done[%0d]: rd=%b wr=%b if_done=%b ls_done=%b, need 0 0 %b %b",
                         t, read, write, if_done, ls_done, !g_ls, g_ls);
            end
            checks++;
            if (if_rdata !== exp_if_rdata || ls_rdata !== exp_ls_rdata) begin
                errors++;
                $display("FAIL rand_rdata[%0d]: if=%h ls=%h, need %h %h",
                         t, if_rdata, ls_rdata, exp_if_rdata, exp_ls_rdata);
            end
            if (g_ls) begin
                ls_pend = 1'b0;
                ls_req  = 1'b0;
            end else begin
                if_pend = 1'b0;
                if_req  = 1'b0;
            end
            waitrequest = 1'($urandom_range(1, 0));
            readdata    = $urandom;
            tick();
            checks++;
            if ({read, write, if_done, ls_done} !== 4'b0000) begin
                errors++;
                $display("FAIL rand_idle[%0d]: rd=%b wr=%b ifd=%b lsd=%b, need 0000",
                         t, read, write, if_done, ls_done);
            end
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store_wait();
        test_load();
        test_simultaneous();
        test_reset_mid();
        test_input_change();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
